// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;
  localparam int WIDTH_MAX = 16;
  localparam int NCH_MAX   = 16;
  localparam int DIV_OFF   = 0;
  localparam int DIV_PASS  = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, active/shadow divisor, pending flag and registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_val_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_sh_q, div_sh_d;
  logic             pend_q, pend_d;
  logic             run_q, run_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  logic             run_ok, wrap, restart, apply;
  logic [WIDTH-1:0] phase;
  logic [WIDTH:0]   half;

  always_comb begin
    run_ok    = en_i && (div_act_q != WIDTH'(DIV_OFF));
    wrap      = run_q && ((div_act_q == WIDTH'(DIV_PASS)) ||
                          (cnt_q == div_act_q - WIDTH'(1)));
    // run_q low means the previous cycle emitted nothing, so the first
    // enabled cycle is phase 0 just like a wrap or a sync.
    restart   = run_ok && (!run_q || sync_i || wrap);
    // A write landing on the apply edge is held back to the next one.
    apply     = pend_q && !wr_i && (!run_ok || restart);
    div_act_d = apply ? div_sh_q : div_act_q;
    div_sh_d  = wr_i ? wr_val_i : div_sh_q;
    pend_d    = wr_i || (pend_q && !apply);
    phase     = restart ? '0 : cnt_q + WIDTH'(1);
    run_d     = run_ok && (div_act_d != WIDTH'(DIV_OFF));
    cnt_d     = run_d ? phase : '0;
    half      = ({1'b0, div_act_d} + (WIDTH+1)'(1)) >> 1;
    tick_d    = run_d && (phase == '0);
    clk_out_d = run_d && ({1'b0, phase} < half);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_act_q <= WIDTH'(DEF_DIV);
      div_sh_q  <= WIDTH'(DEF_DIV);
      pend_q    <= 1'b0;
      run_q     <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_sh_q  <= div_sh_d;
      pend_q    <= pend_d;
      run_q     <= run_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent run-time programmable clock dividers sharing one system clock.
// Top level only decodes divisor writes and fans out sync/rst.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WIDTH   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic                                    clk_100MHz,
  input  logic                                    rst,
  input  logic [NCH-1:0]                          ch_en,
  input  logic                                    div_wr,
  input  logic [((NCH > 1) ? clog2(NCH) : 1)-1:0] div_ch,
  input  logic [WIDTH-1:0]                        div_val,
  input  logic                                    sync,
  output logic [NCH-1:0]                          clk_out,
  output logic [NCH-1:0]                          tick,
  output logic [NCH-1:0]                          pend
);

  localparam int CHW = (NCH > 1) ? clog2(NCH) : 1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_sel;
    // Addresses at or above NCH match no channel and are dropped.
    assign wr_sel = div_wr && (div_ch == CHW'(i));

    clk_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_i     (clk_100MHz),
      .rst_i     (rst),
      .en_i      (ch_en[i]),
      .sync_i    (sync),
      .wr_i      (wr_sel),
      .wr_val_i  (div_val),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i]),
      .pend_o    (pend[i])
    );
  end

endmodule
